// File: rtl/join_block.sv
// join_block: clocked 4-phase join controller. Two upstream requesters are
// merged into one downstream request; both are acknowledged together. The
// block also synchronises its asynchronous inputs, flags 4-phase protocol
// violations and keeps transaction-count and arrival-skew statistics.
module join_block #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16,
  parameter int SKEW_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_in1,
  output logic               ack_in1,
  input  logic               req_in2,
  output logic               ack_in2,
  output logic               req_out,
  input  logic               ack_out,
  input  logic               err_clr,
  output logic               proto_err,
  output logic [COUNT_W-1:0] tx_count,
  output logic [SKEW_W-1:0]  max_skew
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync1_q, sync2_q, synca_q;
  logic                   r1, r2, a;
  logic                   r1Prev_q, r2Prev_q;
  logic                   rise1, rise2, fall1, fall2;

  logic                   reqOut_q, reqOut_d;
  logic                   ack_q, ack_d;
  logic                   protoErr_q, protoErr_d;
  logic                   violation;
  logic [COUNT_W-1:0]     txCount_q, txCount_d;
  logic [SKEW_W-1:0]      skewCnt_q, skewCnt_d;
  logic [SKEW_W-1:0]      maxSkew_q, maxSkew_d;

  // Synchroniser chains for the three asynchronous inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      synca_q <= '0;
    end else begin
      sync1_q[0] <= req_in1;
      sync2_q[0] <= req_in2;
      synca_q[0] <= ack_out;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync1_q[i] <= sync1_q[i-1];
        sync2_q[i] <= sync2_q[i-1];
        synca_q[i] <= synca_q[i-1];
      end
    end
  end

  assign r1 = sync1_q[SYNC_STAGES-1];
  assign r2 = sync2_q[SYNC_STAGES-1];
  assign a  = synca_q[SYNC_STAGES-1];

  assign rise1 = r1 & ~r1Prev_q;
  assign rise2 = r2 & ~r2Prev_q;
  assign fall1 = ~r1 & r1Prev_q;
  assign fall2 = ~r2 & r2Prev_q;

  // State, registered outputs, statistics and one-cycle history of r1/r2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      reqOut_q   <= 1'b0;
      ack_q      <= 1'b0;
      protoErr_q <= 1'b0;
      txCount_q  <= '0;
      skewCnt_q  <= '0;
      maxSkew_q  <= '0;
      r1Prev_q   <= 1'b0;
      r2Prev_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      reqOut_q   <= reqOut_d;
      ack_q      <= ack_d;
      protoErr_q <= protoErr_d;
      txCount_q  <= txCount_d;
      skewCnt_q  <= skewCnt_d;
      maxSkew_q  <= maxSkew_d;
      r1Prev_q   <= r1;
      r2Prev_q   <= r2;
    end
  end

  // Next-state, violation detection and statistics update. Violations never
  // change the transitions; they only feed the sticky error flag.
  always_comb begin
    state_d   = state_q;
    violation = 1'b0;
    txCount_d = txCount_q;
    skewCnt_d = skewCnt_q;
    maxSkew_d = maxSkew_q;
    case (state_q)
      IDLE: begin
        if (a) violation = 1'b1;
        if (r1 && r2) begin
          state_d   = REQ;
          if (skewCnt_q > maxSkew_q) maxSkew_d = skewCnt_q;
          skewCnt_d = '0;
        end else if (r1 ^ r2) begin
          if (skewCnt_q != '1) skewCnt_d = skewCnt_q + SKEW_W'(1);
        end
      end
      REQ: begin
        if (fall1 || fall2) violation = 1'b1;
        if (a) state_d = ACK;
      end
      ACK: begin
        if (rise1 || rise2) violation = 1'b1;
        if (!r1 && !r2) state_d = REL;
      end
      REL: begin
        if (rise1 || rise2) violation = 1'b1;
        if (!a) begin
          state_d   = IDLE;
          txCount_d = txCount_q + COUNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (violation)    protoErr_d = 1'b1;
    else if (err_clr) protoErr_d = 1'b0;
    else              protoErr_d = protoErr_q;

    reqOut_d = (state_d == REQ) || (state_d == ACK);
    ack_d    = (state_d == ACK) || (state_d == REL);
  end

  assign req_out   = reqOut_q;
  assign ack_in1   = ack_q;
  assign ack_in2   = ack_q;
  assign proto_err = protoErr_q;
  assign tx_count  = txCount_q;
  assign max_skew  = maxSkew_q;

endmodule

// File: tb/tb_join_block.sv
// tb_join_block: directed bench for join_block with hand-computed expectations
// (SYNC_STAGES=2, so each input change is seen by the outputs 3 edges later).
module tb_join_block;

  logic       clk;
  logic       rst;
  logic       req_in1, req_in2, ack_out, err_clr;
  logic       ack_in1, ack_in2, req_out, proto_err;
  logic [3:0] tx_count;
  logic [7:0] max_skew;

  int passCount  = 0;
  int checkCount = 0;

  join_block #(
    .SYNC_STAGES(2),
    .COUNT_W    (4),
    .SKEW_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in1  (req_in1),
    .ack_in1  (ack_in1),
    .req_in2  (req_in2),
    .ack_in2  (ack_in2),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .err_clr  (err_clr),
    .proto_err(proto_err),
    .tx_count (tx_count),
    .max_skew (max_skew)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic r1v, input logic r2v, input logic av);
    req_in1 = r1v;
    req_in2 = r2v;
    ack_out = av;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // One complete handshake with the given arrival skew, downstream echoing.
  task automatic runTx(input int skew);
    applyStimulus(1, 0, 0);
    ticks(skew);
    applyStimulus(1, 1, 0);
    ticks(3);
    applyStimulus(1, 1, 1);
    ticks(3);
    applyStimulus(0, 0, 1);
    ticks(3);
    applyStimulus(0, 0, 0);
    ticks(3);
  endtask

  initial begin
    rst     = 1'b0;
    err_clr = 1'b0;
    applyStimulus(0, 0, 0);
    ticks(2);
    checkOutput("reset_req_out", req_out, 0);
    checkOutput("reset_ack_in1", ack_in1, 0);
    checkOutput("reset_ack_in2", ack_in2, 0);
    checkOutput("reset_proto_err", proto_err, 0);
    checkOutput("reset_tx_count", tx_count, 0);
    checkOutput("reset_max_skew", max_skew, 0);
    rst = 1'b1;
    tick();

    // Basic join, simultaneous arrival
    applyStimulus(1, 1, 0);
    ticks(2);
    checkOutput("basic_req_out_early", req_out, 0);
    tick();
    checkOutput("basic_req_out_rise", req_out, 1);
    checkOutput("basic_ack_before", ack_in1, 0);
    applyStimulus(1, 1, 1);
    ticks(2);
    checkOutput("basic_ack_early", ack_in1, 0);
    tick();
    checkOutput("basic_ack_in1", ack_in1, 1);
    checkOutput("basic_ack_in2", ack_in2, 1);
    checkOutput("basic_req_out_hold", req_out, 1);
    applyStimulus(0, 0, 1);
    ticks(3);
    checkOutput("basic_rel_req_out", req_out, 0);
    checkOutput("basic_rel_ack", ack_in1, 1);
    applyStimulus(0, 0, 0);
    ticks(3);
    checkOutput("basic_idle_ack_in1", ack_in1, 0);
    checkOutput("basic_idle_ack_in2", ack_in2, 0);
    checkOutput("basic_tx_count", tx_count, 1);
    checkOutput("basic_max_skew", max_skew, 0);
    checkOutput("basic_proto_err", proto_err, 0);

    // Skewed arrival: req_in2 ten cycles after req_in1
    applyStimulus(1, 0, 0);
    ticks(10);
    checkOutput("skew_wait_req_out", req_out, 0);
    applyStimulus(1, 1, 0);
    ticks(2);
    checkOutput("skew_req_out_early", req_out, 0);
    tick();
    checkOutput("skew_req_out_rise", req_out, 1);
    checkOutput("skew_max_10", max_skew, 10);
    applyStimulus(1, 1, 1);
    ticks(3);
    applyStimulus(0, 0, 1);
    ticks(3);
    applyStimulus(0, 0, 0);
    ticks(3);
    checkOutput("skew_tx_count", tx_count, 2);
    runTx(4);
    checkOutput("skew_max_kept", max_skew, 10);
    checkOutput("skew_tx_count2", tx_count, 3);
    checkOutput("skew_proto_err", proto_err, 0);

    // Staggered release: req_in1 drops 5 cycles before req_in2
    applyStimulus(1, 1, 0);
    ticks(3);
    applyStimulus(1, 1, 1);
    ticks(3);
    checkOutput("stag_in_ack", ack_in1, 1);
    applyStimulus(0, 1, 1);
    ticks(5);
    checkOutput("stag_held_req_out", req_out, 1);
    applyStimulus(0, 0, 1);
    ticks(2);
    checkOutput("stag_req_out_late", req_out, 1);
    tick();
    checkOutput("stag_req_out_fall", req_out, 0);
    applyStimulus(0, 0, 0);
    ticks(3);
    checkOutput("stag_proto_err", proto_err, 0);
    checkOutput("stag_tx_count", tx_count, 4);

    // Violation: req_in2 dropped while in REQ
    applyStimulus(1, 1, 0);
    ticks(3);
    checkOutput("viol_in_req", req_out, 1);
    applyStimulus(1, 0, 0);
    ticks(2);
    checkOutput("viol_req_drop_early", proto_err, 0);
    tick();
    checkOutput("viol_req_drop", proto_err, 1);
    checkOutput("viol_req_out_kept", req_out, 1);
    applyStimulus(1, 1, 1);
    ticks(3);
    applyStimulus(0, 0, 1);
    ticks(3);
    applyStimulus(0, 0, 0);
    ticks(3);
    checkOutput("viol_tx_count", tx_count, 5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("viol_err_clr", proto_err, 0);

    // Violation: ack_out raised while idle, then clear racing a new violation
    applyStimulus(0, 0, 1);
    ticks(2);
    checkOutput("viol_idle_ack_early", proto_err, 0);
    tick();
    checkOutput("viol_idle_ack", proto_err, 1);
    checkOutput("viol_idle_req_out", req_out, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("viol_set_wins", proto_err, 1);
    applyStimulus(0, 0, 0);
    ticks(3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("viol_final_clr", proto_err, 0);

    // Wrap of the 4-bit transaction counter
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("wrap_start", tx_count, 0);
    for (int t = 0; t < 16; t++) runTx(0);
    checkOutput("wrap_16", tx_count, 0);
    runTx(0);
    checkOutput("wrap_17", tx_count, 1);

    // Reset asserted while in ACK
    applyStimulus(1, 1, 0);
    ticks(3);
    applyStimulus(1, 1, 1);
    ticks(3);
    checkOutput("midrst_in_ack", ack_in1, 1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_req_out", req_out, 0);
    checkOutput("midrst_ack_in1", ack_in1, 0);
    checkOutput("midrst_ack_in2", ack_in2, 0);
    checkOutput("midrst_tx_count", tx_count, 0);
    applyStimulus(0, 0, 0);
    tick();
    rst = 1'b1;
    ticks(4);
    checkOutput("postrst_req_out", req_out, 0);
    checkOutput("postrst_ack", ack_in1, 0);
    checkOutput("postrst_max_skew", max_skew, 0);
    applyStimulus(1, 1, 0);
    ticks(3);
    checkOutput("postrst_idle_join", req_out, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/join_block.md
Name: join_block

Overview:
Clocked 4-phase join controller, the converging counterpart of the fork element. Two upstream requesters (req_in1/ack_in1, req_in2/ack_in2) are merged into a single downstream request (req_out/ack_out). req_out fires only when both requesters are up, and both are acknowledged together. It sits where two parallel controller branches re-converge before a shared stage. It also adds input synchronisation, protocol-violation detection and transaction/skew statistics.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (req_in1, req_in2, ack_out); legal range 1..4
COUNT_W, 16, width of tx_count
SKEW_W, 8, width of max_skew

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (rst=0 resets)
req_in1  in  1  request from requester 1 (async)
ack_in1  out  1  acknowledge to requester 1
req_in2  in  1  request from requester 2 (async)
ack_in2  out  1  acknowledge to requester 2
req_out  out  1  joined request to downstream controller
ack_out  in  1  acknowledge from downstream controller (async)
err_clr  in  1  synchronous pulse; clears proto_err
proto_err  out  1  sticky 4-phase protocol violation flag
tx_count  out  COUNT_W  completed joined transactions, wraps modulo 2^COUNT_W
max_skew  out  SKEW_W  largest observed arrival gap between the two rising requests, in cycles, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; req_out=0; ack_in1=ack_in2=0; proto_err=0; tx_count=0; max_skew=0; synchroniser flops=0; skew counter=0. Deassertion takes effect at the next clk edge.
- All outputs are registered. ack_in1 and ack_in2 are always equal.
- The FSM uses only the synchronised signals r1, r2 and a.
- FSM states and transitions:
  - IDLE (req_out=0, ack=0): r1&r2 -> REQ.
  - REQ (req_out=1, ack=0): a=1 -> ACK.
  - ACK (req_out=1, ack=1): r1=0 & r2=0 -> REL. A requester that drops early is held; wait for the other.
  - REL (req_out=0, ack=1): a=0 -> IDLE. tx_count increments on this transition.
- Latency: req_out rises on the (SYNC_STAGES+1)-th clk edge after the later of req_in1/req_in2 goes high. Each later phase likewise costs SYNC_STAGES+1 edges per input change.
- Skew measurement:
  - In IDLE, when exactly one of r1/r2 is high, the skew counter increments each cycle, saturating at 2^SKEW_W-1.
  - On IDLE->REQ: max_skew = max(max_skew, counter), then the counter clears.
  - Simultaneous arrival records 0.
- Protocol errors set proto_err (sticky) on any of:
  - a=1 while in IDLE;
  - r1 or r2 falls while in REQ;
  - r1 or r2 rises again in ACK after having fallen;
  - r1 or r2 rises while in REL.
- An error does not alter FSM transitions; the FSM continues per the rules above.
- err_clr=1 clears proto_err on that edge. If a new violation occurs in the same cycle, set wins.
- A requester high in IDLE with the other low is legal: the block waits indefinitely.
- tx_count wraps from 2^COUNT_W-1 to 0 with no flag.
- Reset asserted mid-transaction forces IDLE and zeroes all outputs immediately. No handshake is completed.

Test Plan:
- Basic join: req_in1 and req_in2 rise on the same cycle, with ack_out echoing req_out after 3 cycles. Expect req_out high 3 edges later (SYNC_STAGES=2), acks high 3 edges after ack_out, full return to zero, tx_count=1, max_skew=0, proto_err=0.
- Skewed arrival: req_in1 rises, req_in2 rises 10 cycles later. Expect req_out to stay 0 until 3 edges after req_in2, then max_skew=10. A second transaction with skew 4 leaves max_skew=10.
- Staggered release: in ACK, req_in1 drops 5 cycles before req_in2. Expect req_out to stay 1 until 3 edges after req_in2 falls, and proto_err=0.
- Violations:
  - req_in2 dropped while in REQ -> proto_err=1.
  - err_clr pulse -> proto_err=0.
  - ack_out raised while idle -> proto_err=1.
- Wrap and reset: with COUNT_W=4, run 17 transactions -> tx_count=1. Then assert rst=0 while in ACK -> req_out=0, acks=0, tx_count=0 immediately, state IDLE after release.
